// File: rtl/draw_arbiter_if.sv
// draw_arbiter_if: bundles the sprite-drawer request side and the VGA adapter
// side of the draw arbiter.
//   req/done/req_plot   per-requester level request, burst-done pulse, pixel strobe
//   req_x/y/colour      packed per-requester pixel fields, requester i at [i*W +: W]
//   grant               one-hot (or zero) grant back to the drawers
//   frame_start/busy    frame accepted pulse / scheduler not idle
//   vga_x/y/colour/plot registered pixel write toward the adapter
//   overrun/timeout     sticky error flags
// modport master: the sprite/top-level side; modport slave: the arbiter.
interface draw_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          done;
    logic [NUM_REQ*X_W-1:0]      req_x;
    logic [NUM_REQ*Y_W-1:0]      req_y;
    logic [NUM_REQ*COLOUR_W-1:0] req_colour;
    logic [NUM_REQ-1:0]          req_plot;
    logic [NUM_REQ-1:0]          grant;
    logic                        frame_start;
    logic                        busy;
    logic [X_W-1:0]              vga_x;
    logic [Y_W-1:0]              vga_y;
    logic [COLOUR_W-1:0]         vga_colour;
    logic                        vga_plot;
    logic                        overrun;
    logic                        timeout;

    modport master (
        output req, done, req_x, req_y, req_colour, req_plot,
        input  grant, frame_start, busy, vga_x, vga_y, vga_colour, vga_plot,
               overrun, timeout
    );

    modport slave (
        input  req, done, req_x, req_y, req_colour, req_plot,
        output grant, frame_start, busy, vga_x, vga_y, vga_colour, vga_plot,
               overrun, timeout
    );
endinterface

// File: rtl/draw_arbiter.sv
// draw_arbiter: frame-synchronous scheduler sharing the single VGA pixel-write
// port among the sprite drawers (index 0 = ship). Each frame tick it optionally
// clears the screen, then gives every requesting drawer one exclusive burst in
// round-robin order; the granted drawer's pixel is forwarded one cycle later.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    draw_arbiter_if.slave (requests in, grant/flags/VGA pixel out)
// Optional feature macro: CLEAR_SCREEN_EN -- when defined, a 160x120 sweep of
// colour 0 runs after each accepted tick, before arbitration.
module draw_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int COLOUR_W     = 3,
    parameter int FRAME_CYCLES = 833334,
    parameter int MAX_BURST    = 4096
) (
    input  logic           clk,
    input  logic           reset,
    draw_arbiter_if.slave  bus
);
    localparam int FC_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_CYCLES - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd2;
    localparam logic [1:0] S_SERVE = 2'd3;
`ifdef CLEAR_SCREEN_EN
    localparam logic [1:0]     S_CLEAR    = 2'd1;
    localparam logic [X_W-1:0] CLR_X_LAST = X_W'(159);
    localparam logic [Y_W-1:0] CLR_Y_LAST = Y_W'(119);
    logic [X_W-1:0] clr_x_q, clr_x_d;
    logic [Y_W-1:0] clr_y_q, clr_y_d;
`endif

    logic [1:0]          state_q, state_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic [BC_W-1:0]     bcnt_q, bcnt_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [NUM_REQ-1:0]  served_q, served_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                frame_start_q, frame_start_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;
    logic [X_W-1:0]      vga_x_q, vga_x_d;
    logic [Y_W-1:0]      vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
    logic                vga_plot_q, vga_plot_d;

    logic                tick;
    logic                arb_found;
    logic [PTR_W-1:0]    arb_idx;

    assign tick = (fcnt_q == FC_LAST);

    // Round-robin search of unserved requesters, starting at the pointer.
    always_comb begin
        int          cand;
        logic [PTR_W-1:0] cidx;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cidx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            cidx = PTR_W'(cand);
            if (!arb_found && bus.req[cidx] && !served_q[cidx]) begin
                arb_found = 1'b1;
                arb_idx   = cidx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        fcnt_d        = tick ? '0 : fcnt_q + 1'b1;
        bcnt_d        = bcnt_q;
        rr_ptr_d      = rr_ptr_q;
        gidx_d        = gidx_q;
        served_d      = served_q;
        grant_d       = grant_q;
        frame_start_d = 1'b0;
        overrun_d     = overrun_q;
        timeout_d     = timeout_q;
        vga_x_d       = vga_x_q;
        vga_y_d       = vga_y_q;
        vga_colour_d  = vga_colour_q;
        vga_plot_d    = 1'b0;
`ifdef CLEAR_SCREEN_EN
        clr_x_d       = clr_x_q;
        clr_y_d       = clr_y_q;
`endif
        // A tick that lands while a frame is still being drawn is dropped.
        if (tick && state_q != S_WAIT) overrun_d = 1'b1;

        case (state_q)
            S_WAIT: begin
                if (tick) begin
                    frame_start_d = 1'b1;
                    served_d      = '0;
`ifdef CLEAR_SCREEN_EN
                    clr_x_d = '0;
                    clr_y_d = '0;
                    state_d = S_CLEAR;
`else
                    state_d = S_ARB;
`endif
                end
            end
`ifdef CLEAR_SCREEN_EN
            S_CLEAR: begin
                vga_x_d      = clr_x_q;
                vga_y_d      = clr_y_q;
                vga_colour_d = '0;
                vga_plot_d   = 1'b1;
                if (clr_x_q == CLR_X_LAST) begin
                    clr_x_d = '0;
                    if (clr_y_q == CLR_Y_LAST) state_d = S_ARB;
                    else                       clr_y_d = clr_y_q + 1'b1;
                end else begin
                    clr_x_d = clr_x_q + 1'b1;
                end
            end
`endif
            S_ARB: begin
                if (arb_found) begin
                    grant_d           = '0;
                    grant_d[arb_idx]  = 1'b1;
                    served_d[arb_idx] = 1'b1;
                    gidx_d            = arb_idx;
                    rr_ptr_d          = (arb_idx == PTR_LAST) ? '0 : arb_idx + 1'b1;
                    bcnt_d            = '0;
                    state_d           = S_SERVE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_SERVE: begin
                // Only the granted requester's fields can reach the adapter.
                vga_x_d      = bus.req_x[gidx_q*X_W +: X_W];
                vga_y_d      = bus.req_y[gidx_q*Y_W +: Y_W];
                vga_colour_d = bus.req_colour[gidx_q*COLOUR_W +: COLOUR_W];
                vga_plot_d   = bus.req_plot[gidx_q];
                if (bus.done[gidx_q]) begin
                    grant_d = '0;
                    state_d = S_ARB;
                end else if (bcnt_q == BC_LAST) begin
                    // Watchdog: requester stays marked served for this frame.
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = S_ARB;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_WAIT;
            fcnt_q        <= '0;
            bcnt_q        <= '0;
            rr_ptr_q      <= '0;
            gidx_q        <= '0;
            served_q      <= '0;
            grant_q       <= '0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_colour_q  <= '0;
            vga_plot_q    <= 1'b0;
`ifdef CLEAR_SCREEN_EN
            clr_x_q       <= '0;
            clr_y_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            bcnt_q        <= bcnt_d;
            rr_ptr_q      <= rr_ptr_d;
            gidx_q        <= gidx_d;
            served_q      <= served_d;
            grant_q       <= grant_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_colour_q  <= vga_colour_d;
            vga_plot_q    <= vga_plot_d;
`ifdef CLEAR_SCREEN_EN
            clr_x_q       <= clr_x_d;
            clr_y_q       <= clr_y_d;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = (state_q != S_WAIT);
    assign bus.vga_x       = vga_x_q;
    assign bus.vga_y       = vga_y_q;
    assign bus.vga_colour  = vga_colour_q;
    assign bus.vga_plot    = vga_plot_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: scoreboard bench for draw_arbiter (default build, no clear).
// Behavioural drawers answer grants with pixels and push the expected adapter
// write (fields + arrival cycle) into a queue; a monitor pops on every vga_plot.
// Grant order, burst spacing, watchdog and overrun flags are checked directly.
module tb_draw_arbiter;
    localparam int NR = 4, XW = 8, YW = 7, CW = 3;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        int            cyc;
    } pix_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    draw_arbiter_if #(.NUM_REQ(NR), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) bus ();

    draw_arbiter #(
        .NUM_REQ(NR), .X_W(XW), .Y_W(YW), .COLOUR_W(CW),
        .FRAME_CYCLES(32), .MAX_BURST(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0;
    pix_t exp_q[$];
    int   rise_q[$], rise_cyc[$], fall_cyc[$], fs_cyc[$];
    int   len[NR];
    bit   nodone[NR];
    int   cnt[NR];
    logic [NR-1:0] gprev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic check_order(input string nm, input int e[4], input int n);
        check({nm, "_count"}, rise_q.size(), n);
        for (int i = 0; i < n && i < rise_q.size(); i++)
            check($sformatf("%s_grant%0d", nm, i), rise_q[i], e[i]);
        rise_q.delete(); rise_cyc.delete(); fall_cyc.delete();
    endtask

    task automatic run_frame(input string nm);
        int t;
        t = 0;
        while (bus.frame_start !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        if (bus.frame_start !== 1'b1) check({nm, "_frame_start_wait"}, 0, 1);
        t = 0;
        while (bus.busy !== 1'b0 && t < 400) begin @(negedge clk); t++; end
        if (bus.busy !== 1'b0) check({nm, "_busy_wait"}, 1, 0);
        @(negedge clk);
    endtask

    // Drawers: granted requester presents one pixel per cycle; the others
    // drive junk pixels and done to prove they are ignored.
    initial begin
        pix_t p;
        bus.done = '0; bus.req_plot = '0;
        bus.req_x = '0; bus.req_y = '0; bus.req_colour = '0;
        forever begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) fs_cyc.push_back(cyc);
            for (int k = 0; k < NR; k++) begin
                if (bus.grant[k] && !gprev[k]) begin
                    rise_q.push_back(k); rise_cyc.push_back(cyc); cnt[k] = 0;
                end
                if (!bus.grant[k] && gprev[k]) fall_cyc.push_back(cyc);
                if (bus.grant[k]) begin
                    p.x = XW'(k*16 + cnt[k]);
                    p.y = YW'(k + cnt[k]);
                    p.c = CW'(k + 1);
                    p.cyc = cyc + 1;
                    bus.req_x[k*XW +: XW]      = p.x;
                    bus.req_y[k*YW +: YW]      = p.y;
                    bus.req_colour[k*CW +: CW] = p.c;
                    bus.req_plot[k] = 1'b1;
                    bus.done[k] = (!nodone[k] && cnt[k] == len[k] - 1);
                    exp_q.push_back(p);
                    cnt[k]++;
                end else begin
                    bus.req_x[k*XW +: XW]      = 8'hEE;
                    bus.req_y[k*YW +: YW]      = 7'h55;
                    bus.req_colour[k*CW +: CW] = 3'd7;
                    bus.req_plot[k] = 1'b1;
                    bus.done[k]     = 1'b1;
                end
            end
            gprev = bus.grant;
        end
    end

    // Scoreboard monitor.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (bus.vga_plot === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_plot: got (%0d,%0d,%0d) at cycle %0d, expected no write",
                             bus.vga_x, bus.vga_y, bus.vga_colour, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.vga_x !== e.x || bus.vga_y !== e.y || bus.vga_colour !== e.c || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL pixel: got (%0d,%0d,%0d)@%0d, expected (%0d,%0d,%0d)@%0d",
                                 bus.vga_x, bus.vga_y, bus.vga_colour, cyc, e.x, e.y, e.c, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        bus.req = '0;
        for (int k = 0; k < NR; k++) begin len[k] = 1; nodone[k] = 1'b0; cnt[k] = 0; end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_grant", int'(bus.grant), 0);
        check("rst_vga_plot", int'(bus.vga_plot), 0);
        check("rst_vga_x", int'(bus.vga_x), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_frame_start", int'(bus.frame_start), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        reset = 1'b0;

        // Test 1: requesters 0 and 2, three pixels each.
        len[0] = 3; len[2] = 3;
        bus.req = 4'b0101;
        run_frame("t1");
        check("t1_arb_gap", (rise_cyc.size() >= 2) ? rise_cyc[1] - rise_cyc[0] : -1, 4);
        check_order("t1", '{0, 2, 0, 0}, 2);
        check("t1_busy_idle", int'(bus.busy), 0);
        check("t1_overrun", int'(bus.overrun), 0);
        check("t1_drained", exp_q.size(), 0);

        // Test 2: round robin across frames, then with the pointer parked at 2.
        reset = 1'b1; @(negedge clk); @(negedge clk); reset = 1'b0;
        exp_q.delete(); rise_q.delete(); rise_cyc.delete(); fall_cyc.delete();
        for (int k = 0; k < NR; k++) len[k] = 1;
        bus.req = 4'b1111;
        run_frame("t2a");
        check_order("t2a", '{0, 1, 2, 3}, 4);
        run_frame("t2b");
        check_order("t2b", '{0, 1, 2, 3}, 4);
        bus.req = 4'b0010;
        run_frame("t2c");
        check_order("t2c", '{1, 0, 0, 0}, 1);
        bus.req = 4'b1111;
        run_frame("t2d");
        check_order("t2d", '{2, 3, 0, 1}, 4);
        check("t2_drained", exp_q.size(), 0);

        // Test 3: requester 3 never finishes; watchdog revokes after 8 cycles.
        nodone[3] = 1'b1; len[1] = 2;
        bus.req = 4'b1010;
        run_frame("t3");
        check("t3_grant3_len", (fall_cyc.size() >= 1 && rise_cyc.size() >= 1) ? fall_cyc[0] - rise_cyc[0] : -1, 8);
        check_order("t3", '{3, 1, 0, 0}, 2);
        check("t3_timeout", int'(bus.timeout), 1);
        check("t3_overrun", int'(bus.overrun), 0);
        check("t3_drained", exp_q.size(), 0);

        // Test 4: four watchdogged bursts outlast a frame -> overrun, tick dropped.
        for (int k = 0; k < NR; k++) nodone[k] = 1'b1;
        fs_cyc.delete();
        bus.req = 4'b1111;
        run_frame("t4");
        check_order("t4", '{2, 3, 0, 1}, 4);
        check("t4_overrun", int'(bus.overrun), 1);
        bus.req = '0;
        run_frame("t4b");
        check("t4_frame_period", (fs_cyc.size() >= 2) ? fs_cyc[1] - fs_cyc[0] : -1, 64);
        check("t4_drained", exp_q.size(), 0);

        // Test 5: reset in the middle of a burst.
        bus.req = 4'b0001;
        t = 0;
        while (bus.grant[0] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        check("t5_grant_seen", int'(bus.grant[0]), 1);
        @(negedge clk);
        check("t5_plot_before_reset", int'(bus.vga_plot), 1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_grant", int'(bus.grant), 0);
        check("t5_vga_plot", int'(bus.vga_plot), 0);
        check("t5_busy", int'(bus.busy), 0);
        check("t5_overrun", int'(bus.overrun), 0);
        check("t5_timeout", int'(bus.timeout), 0);
        check("t5_frame_start", int'(bus.frame_start), 0);
        reset = 1'b0;
        bus.req = '0;
        exp_q.delete();
        repeat (4) @(negedge clk);
        check("t5_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
